// File: rtl/vga_timing_gen.sv
// Raster timing generator (default 640x480@60), one pixel per pix_en strobe, all outputs registered.
// Defining VGA_FRAME_CNT_EN enables the frame_cnt register; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] r_h, r_v;
   logic [9:0] w_h_nxt, w_v_nxt;
   logic       w_de_nxt, w_frame_wrap;
   logic       r_hsync, r_vsync, r_de, r_fs;
   logic [9:0] r_x, r_y;

   // Outputs decode the *next* counter value so they land on the same edge as the step.
   always_comb begin
      w_h_nxt = r_h + 10'd1;
      w_v_nxt = r_v;
      if (r_h == H_LAST) begin
         w_h_nxt = '0;
         w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 10'd1;
      end
      w_de_nxt     = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
      w_frame_wrap = (w_h_nxt == '0) && (w_v_nxt == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h     <= H_LAST;
         r_v     <= V_LAST;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_de    <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_fs    <= 1'b0;
      end else begin
         r_fs <= 1'b0;
         if (pix_en) begin
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_hsync <= !((w_h_nxt >= H_SS) && (w_h_nxt < H_SE));
            r_vsync <= !((w_v_nxt >= V_SS) && (w_v_nxt < V_SE));
            r_de    <= w_de_nxt;
            r_x     <= w_de_nxt ? w_h_nxt : '0;
            r_y     <= w_de_nxt ? w_v_nxt : '0;
            r_fs    <= w_frame_wrap;
         end
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] r_frame_cnt;
   logic       r_started;

   // The first frame after reset is frame 0, so its start pulse does not count up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
         r_started   <= 1'b0;
      end else if (pix_en) begin
         r_started <= 1'b1;
         if (w_frame_wrap && r_started)
            r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   assign frame_cnt = r_frame_cnt;
`else
   assign frame_cnt = '0;
`endif

   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign x           = r_x;
   assign y           = r_y;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing instance A for line/stall checks, tiny-timing instance B (15x8) for frame checks.
module tb_vga_timing_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pe_a = 1'b0, pe_b = 1'b0;
   logic       hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
   logic [9:0] x_a, y_a, x_b, y_b;
   logic [7:0] fc_a, fc_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_a (
      .clk(clk), .rst(rst), .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
      .x(x_a), .y(y_a), .frame_start(fs_a), .frame_cnt(fc_a)
   );

   // H: 8 active, fp 8..9, sync 10..12, bp 13..14. V: 4 active, fp 4, sync 5..6, bp 7.
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_b (
      .clk(clk), .rst(rst), .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
      .x(x_b), .y(y_b), .frame_start(fs_b), .frame_cnt(fc_b)
   );

   typedef struct {
      int   n;
      logic hs, vs, de;
      int   x, y;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_a(input string t, input int hs, input int vs, input int de, input int x,
                        input int y, input int fs);
      chk({t, ".hsync"}, int'(hs_a), hs);
      chk({t, ".vsync"}, int'(vs_a), vs);
      chk({t, ".de"}, int'(de_a), de);
      chk({t, ".x"}, int'(x_a), x);
      chk({t, ".y"}, int'(y_a), y);
      chk({t, ".fs"}, int'(fs_a), fs);
   endtask

   task automatic chk_b(input string t, input int hs, input int vs, input int de, input int x,
                        input int y, input int fs);
      chk({t, ".hsync"}, int'(hs_b), hs);
      chk({t, ".vsync"}, int'(vs_b), vs);
      chk({t, ".de"}, int'(de_b), de);
      chk({t, ".x"}, int'(x_b), x);
      chk({t, ".y"}, int'(y_b), y);
      chk({t, ".fs"}, int'(fs_b), fs);
   endtask

   // A: one idle clk then one strobe; returns just after the strobe edge.
   task automatic step_a();
      @(posedge clk); #1;
      pe_a = 1'b1;
      @(posedge clk); #1;
      pe_a = 1'b0;
   endtask

   // B: back-to-back calls keep pix_en continuously high.
   task automatic step_b();
      pe_b = 1'b1;
      @(posedge clk); #1;
      pe_b = 1'b0;
   endtask

   function automatic int exp_fc(input int pulses);
`ifdef VGA_FRAME_CNT_EN
      return (pulses - 1) % 256;
`else
      return 0 * pulses;
`endif
   endfunction

   vec_t tbl[9];
   int   cnt_a;

   initial begin
      tbl[0] = '{n: 2,   hs: 1, vs: 1, de: 1, x: 1,   y: 0};
      tbl[1] = '{n: 640, hs: 1, vs: 1, de: 1, x: 639, y: 0};
      tbl[2] = '{n: 641, hs: 1, vs: 1, de: 0, x: 0,   y: 0};
      tbl[3] = '{n: 656, hs: 1, vs: 1, de: 0, x: 0,   y: 0};
      tbl[4] = '{n: 657, hs: 0, vs: 1, de: 0, x: 0,   y: 0};
      tbl[5] = '{n: 752, hs: 0, vs: 1, de: 0, x: 0,   y: 0};
      tbl[6] = '{n: 753, hs: 1, vs: 1, de: 0, x: 0,   y: 0};
      tbl[7] = '{n: 800, hs: 1, vs: 1, de: 0, x: 0,   y: 0};
      tbl[8] = '{n: 801, hs: 1, vs: 1, de: 1, x: 0,   y: 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_a("rst_a", 1, 1, 0, 0, 0, 0);
      chk("rst_a.fcnt", int'(fc_a), 0);
      chk_b("rst_b", 1, 1, 0, 0, 0, 0);
      rst = 1'b0;

      // First strobe enters (0,0) with a one-clk frame_start
      step_a();
      cnt_a = 1;
      chk_a("first", 1, 1, 1, 0, 0, 1);
      chk("first.fcnt", int'(fc_a), exp_fc(1));
      @(posedge clk); #1;
      chk_a("first_idle", 1, 1, 1, 0, 0, 0);

      // Horizontal region boundaries
      for (int i = 0; i < 9; i++) begin
         while (cnt_a < tbl[i].n) begin
            step_a();
            cnt_a++;
         end
         chk_a($sformatf("vec%0d", i), int'(tbl[i].hs), int'(tbl[i].vs), int'(tbl[i].de),
               tbl[i].x, tbl[i].y, 0);
      end

      // Full line 1: sync width, sync start, active width, period
      begin
         int hl = 0, dh = 0, hstart = -1;
         for (int i = 0; i < 800; i++) begin
            if (!hs_a) hl++;
            if (!hs_a && hstart < 0) hstart = i;
            if (de_a) dh++;
            step_a();
         end
         chk("line.hsync_low", hl, 96);
         chk("line.hsync_start", hstart, 656);
         chk("line.de_high", dh, 640);
         chk_a("line.period", 1, 1, 1, 0, 2, 0);
      end

      // Stall at x=320
      repeat (320) step_a();
      chk_a("pre_stall", 1, 1, 1, 320, 2, 0);
      begin
         int moved = 0;
         repeat (100) begin
            @(posedge clk); #1;
            if (!(hs_a && vs_a && de_a && x_a == 10'd320 && y_a == 10'd2 && !fs_a)) moved++;
         end
         chk("stall.changes", moved, 0);
      end
      step_a();
      chk_a("post_stall", 1, 1, 1, 321, 2, 0);

      // Instance B: a full frame
      step_b();
      chk_b("b_first", 1, 1, 1, 0, 0, 1);
      begin
         int vl = 0, dh = 0, hl = 0, fp = 0, vstart = -1;
         for (int i = 0; i < 120; i++) begin
            if (!vs_b) vl++;
            if (!vs_b && vstart < 0) vstart = i;
            if (de_b) dh++;
            if (!hs_b) hl++;
            if (fs_b) fp++;
            if (i == 119) chk_b("b_last_px", 1, 1, 0, 0, 0, 0);
            step_b();
         end
         chk("frame.vsync_low", vl, 30);
         chk("frame.vsync_start", vstart, 75);
         chk("frame.de_high", dh, 32);
         chk("frame.hsync_low", hl, 24);
         chk("frame.fs_pulses", fp, 1);
         chk_b("frame.period", 1, 1, 1, 0, 0, 1);
      end

      // Mid-frame asynchronous reset
      repeat (35) step_b();
      chk_b("b_mid", 1, 1, 1, 5, 2, 0);
      rst = 1'b1;
      #1;
      chk_b("async_rst", 1, 1, 0, 0, 0, 0);
      chk("async_rst.fcnt", int'(fc_b), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      step_b();
      chk_b("rst_restart", 1, 1, 1, 0, 0, 1);

      // Frame counter across 257 frame starts
      begin
         int pulses = 1, guard = 0;
         chk("fcnt.p1", int'(fc_b), exp_fc(1));
         while (pulses < 257 && guard < 40000) begin
            step_b();
            guard++;
            if (fs_b) begin
               pulses++;
               if (pulses == 2 || pulses == 256 || pulses == 257)
                  chk($sformatf("fcnt.p%0d", pulses), int'(fc_b), exp_fc(pulses));
            end
         end
         if (pulses < 257) chk("fcnt.timeout", pulses, 257);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
